if_id_stage: RTL and testbench
==============================

# if_id_stage

IF/ID pipeline stage of the five-stage RISC-V core. It registers the instruction word and PC produced by the fetch stage each cycle. It detects load-use hazards against the instruction in EX and drives the fetch stall (`stop`) plus a bubble request toward ID/EX. On control-flow redirects from EX it discards the wrong-path instruction.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.

Ports:
- `clk_cpu`  in  1: core clock; all state updates on the rising edge.
- `rst_cpu`  in  1: reset, synchronous, active-low.
- `if_inst`  in  XLEN: instruction word from IROM for the current fetch PC.
- `if_pc`  in  XLEN: current fetch PC.
- `redirect`  in  1: EX resolved a taken branch, JAL or JALR (same cycle IF loads the new PC).
- `ex_mem_read`  in  1: instruction in EX is a load.
- `ex_rd`  in  5: destination register of the EX instruction.
- `stop`  out  1: fetch stall; IF holds its PC while high.
- `id_bubble`  out  1: ID/EX must load a NOP this cycle.
- `id_inst`  out  XLEN: registered instruction presented to decode.
- `id_pc`  out  XLEN: registered PC of `id_inst`.
- `id_valid`  out  1: `id_inst`/`id_pc` hold a real instruction.
- `stall_cnt`  out  32: load-use stall cycles (see Configuration).
- `flush_cnt`  out  32: redirect flush events (see Configuration).

## Operation
Warm-up:
- IF leaves reset at PC 0xFFFF_FFFC, which is not a real fetch.
- A 1-bit `fetch_ok` register clears on reset and sets on the first clock with reset released.
- IF/ID captures `valid = fetch_ok`, so the word fetched at 0xFFFF_FFFC never becomes valid.

Hazard detection (combinational on the registered ID instruction):
- Decode opcode `id_inst[6:0]`.
- `uses_rs1` is high for every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- `uses_rs2` is high only for R-type (0110011), STORE (0100011) and BRANCH (1100011).
- `hazard = id_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd))`.
- `stop = hazard & ~redirect`.
- `id_bubble = hazard | redirect`.

Register update per edge, highest priority first:
1. Reset low: `id_inst` = 0x0000_0013 (NOP), `id_pc` = 0, `id_valid` = 0, `fetch_ok` = 0.
2. `redirect`: `id_valid` = 0 and `id_inst` = NOP; the wrong-path fetch is dropped. Any pending hazard is discarded.
3. `stop`: hold `id_inst`, `id_pc` and `id_valid` unchanged.
4. Otherwise: `id_inst` = `if_inst`, `id_pc` = `if_pc`, `id_valid` = `fetch_ok`.

Downstream contract:
- When `id_valid` = 0, `id_inst` is NOP.
- Decode must not act on an instruction while `id_bubble` is high.

## Timing
- Latency is one cycle: an instruction fetched in cycle N is valid in ID in cycle N+1.
- A load-use hazard costs exactly one stall cycle:
  - Once the load advances from EX, `ex_mem_read` drops, `hazard` drops and `stop` releases.
  - `stop` is never high for two consecutive cycles for the same load.
- Redirect flushes only the instruction entering IF/ID on that edge; the ID/EX flush is covered by `id_bubble`.
- Redirect and hazard in the same cycle: flush wins and `stop` = 0, so IF takes the redirect target.
- Reset mid-stall: the next edge returns every output to its reset value and `stop` = 0 (`id_valid` = 0 forces `hazard` low).
- Reset values: `stop` = 0, `id_bubble` = 0, `id_inst` = 0x0000_0013, `id_pc` = 0, `id_valid` = 0, `stall_cnt` = 0, `flush_cnt` = 0.

## Configuration
- `IF_ID_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every edge with `stop` high.
  - `flush_cnt` increments on every edge with `redirect` high.
  - Both are 32-bit, wrap 0xFFFF_FFFF → 0, and clear on reset.
- Not defined: both counters are tied to constant 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset release:
  - Stimulus: hold reset low 3 cycles, then release with IF sequencing PC 0xFFFF_FFFC, 0, 4.
  - Response: `id_valid` = 0 for the first captured word; `id_pc` = 0 with `id_valid` = 1 one edge later.
- Load-use:
  - Stimulus: ID holds `add x3,x1,x2` (0x002081B3); `ex_mem_read` = 1, `ex_rd` = 1.
  - Response: `stop` = 1 and `id_bubble` = 1 for one cycle with `id_inst` held; next cycle `ex_mem_read` = 0 and `stop` = 0.
- No false hazard:
  - Stimulus: `lui x1,...` in ID with `ex_rd` = 1 and load in EX → `stop` = 0.
  - Stimulus: `ex_rd` = 0 with an `add` reading x0 → `stop` = 0.
- Redirect:
  - Stimulus: `redirect` = 1 while IF/ID would capture PC 0x20.
  - Response: `id_valid` = 0 and `id_inst` = 0x13 next cycle; the target PC becomes valid the cycle after.
- Simultaneous redirect and hazard:
  - Stimulus: hazard condition true and `redirect` = 1 in the same cycle.
  - Response: `stop` = 0, `id_bubble` = 1, `id_valid` = 0 after the edge.
- Perf counters, built with `IF_ID_PERF_CNT_EN`:
  - Stimulus: 3 load-use stalls and 2 redirects.
  - Response: `stall_cnt` = 3, `flush_cnt` = 2.
  - Without the macro: both read 0.

Source files
------------

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use hazard stall and redirect flush
//
// Registers the fetched instruction/PC for decode, suppresses the warm-up
// fetch at PC 0xFFFF_FFFC, stalls fetch for one cycle on a load-use hazard
// against EX, and drops the wrong-path fetch on an EX redirect.
//
// Optional feature macro: IF_ID_PERF_CNT_EN (stall/flush performance counters).
//
// Ports:
//   clk_cpu      in   core clock, rising edge
//   rst_cpu      in   synchronous active-low reset
//   if_inst      in   fetched instruction word
//   if_pc        in   fetch PC
//   redirect     in   EX taken branch / JAL / JALR
//   ex_mem_read  in   EX instruction is a load
//   ex_rd        in   EX destination register
//   stop         out  fetch stall
//   id_bubble    out  ID/EX loads a NOP this cycle
//   id_inst      out  instruction presented to decode
//   id_pc        out  PC of id_inst
//   id_valid     out  id_inst/id_pc are a real instruction
//   stall_cnt    out  load-use stall cycle count (0 when counters not built)
//   flush_cnt    out  redirect flush count (0 when counters not built)

module if_id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_cpu,
    input  logic            rst_cpu,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            redirect,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic            stop,
    output logic            id_bubble,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    localparam logic [XLEN-1:0] NOP_INST  = XLEN'(32'h0000_0013);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Low only for the first cycle out of reset, when IF still presents the
    // pre-reset PC 0xFFFF_FFFC rather than a real fetch.
    logic       fetch_ok;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hazard;

    assign opcode = id_inst[6:0];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    // Register-field use is decided on opcode alone; a spurious match on an
    // unused field would only cost an extra stall, never correctness, but the
    // U/J formats are excluded because their immediates overlap rs1.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:      uses_rs1 = 1'b0;
            OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

    // A redirect kills the dependent instruction anyway, so IF must be free
    // to load the redirect target instead of stalling.
    assign stop      = hazard & ~redirect;
    assign id_bubble = hazard | redirect;

    always_ff @(posedge clk_cpu) begin
        if (!rst_cpu) begin
            id_inst  <= NOP_INST;
            id_pc    <= '0;
            id_valid <= 1'b0;
            fetch_ok <= 1'b0;
        end else begin
            fetch_ok <= 1'b1;
            if (redirect) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else if (!stop) begin
                id_inst  <= if_inst;
                id_pc    <= if_pc;
                id_valid <= fetch_ok;
            end
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_cpu) begin
        if (!rst_cpu) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stop) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard testbench for if_id_stage

module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_cpu = 1'b0;
    logic        rst_cpu;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redirect;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        stop;
    logic        id_bubble;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always #5 clk_cpu = ~clk_cpu;

    if_id_stage #(.XLEN(32)) dut (
        .clk_cpu     (clk_cpu),
        .rst_cpu     (rst_cpu),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .redirect    (redirect),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .stop        (stop),
        .id_bubble   (id_bubble),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic        stop;
        logic        bubble;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural view of what decode should see.
    logic [31:0] m_inst, m_pc, m_sc, m_fc;
    logic        m_valid, m_fok;
    bit          last_stop;

    function automatic bit model_hazard(logic [31:0] inst, bit valid, bit mr, logic [4:0] rd);
        logic [6:0] op;
        bit r1, r2;
        op = inst[6:0];
        r1 = !(op inside {7'h37, 7'h17, 7'h6f});
        r2 = (op inside {7'h33, 7'h23, 7'h63});
        return valid && mr && (rd != 5'd0) &&
               ((r1 && inst[19:15] == rd) || (r2 && inst[24:20] == rd));
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, record expected outputs for this cycle,
    // then advance the model across the coming edge.
    task automatic step(input logic rst, input logic [31:0] inst, input logic [31:0] pc,
                        input logic redir, input logic mr, input logic [4:0] rd, input bit chk);
        exp_t e;
        bit   hz, st;
        @(negedge clk_cpu);
        #1;
        rst_cpu = rst; if_inst = inst; if_pc = pc;
        redirect = redir; ex_mem_read = mr; ex_rd = rd;
        hz = model_hazard(m_inst, m_valid, mr, rd);
        st = hz && !redir;
        e.inst = m_inst; e.pc = m_pc; e.valid = m_valid;
        e.stop = st; e.bubble = hz || redir; e.sc = m_sc; e.fc = m_fc;
        if (chk) sbq.push_back(e);
        if (!rst) begin
            m_inst = NOP; m_pc = 0; m_valid = 0; m_fok = 0; m_sc = 0; m_fc = 0;
        end else begin
`ifdef IF_ID_PERF_CNT_EN
            if (st) m_sc = m_sc + 1;
            if (redir) m_fc = m_fc + 1;
`endif
            if (redir) begin
                m_valid = 0; m_inst = NOP;
            end else if (!st) begin
                m_inst = inst; m_pc = pc; m_valid = m_fok;
            end
            m_fok = 1;
        end
        last_stop = st;
    endtask

    // Monitor: outputs are presented every cycle; compare once inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_cpu);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp("id_inst",   id_inst,   e.inst);
                cmp("id_pc",     id_pc,     e.pc);
                cmp("id_valid",  {31'd0, id_valid},  {31'd0, e.valid});
                cmp("stop",      {31'd0, stop},      {31'd0, e.stop});
                cmp("id_bubble", {31'd0, id_bubble}, {31'd0, e.bubble});
                cmp("stall_cnt", stall_cnt, e.sc);
                cmp("flush_cnt", flush_cnt, e.fc);
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [8];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 7)];
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic [31:0] pc, inst;
        logic        rs, rd_r, mr;
        int          wait_cyc;
        rst_cpu = 0; if_inst = NOP; if_pc = 0; redirect = 0; ex_mem_read = 0; ex_rd = 0;
        m_inst = NOP; m_pc = 0; m_valid = 0; m_fok = 0; m_sc = 0; m_fc = 0; last_stop = 0;

        // Reset held 3 cycles, then warm-up sequence FFFF_FFFC, 0, 4.
        step(0, NOP, 32'h0, 0, 0, 0, 0);
        step(0, NOP, 32'h0, 0, 0, 0, 1);
        step(0, NOP, 32'h0, 0, 0, 0, 1);
        step(1, 32'h0000_0033, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step(1, 32'h0000_0013, 32'h0, 0, 0, 0, 1);
        step(1, 32'h0020_81B3, 32'h4, 0, 0, 0, 1);
        // ID now holds add x3,x1,x2; load to x1 in EX -> one stall.
        step(1, 32'h0000_0013, 32'h8, 0, 1, 1, 1);
        step(1, 32'h0000_0013, 32'h8, 0, 0, 0, 1);
        // lui x1 with immediate overlapping rs1 field: no hazard.
        step(1, 32'h0000_80B7, 32'hC, 0, 0, 0, 1);
        step(1, 32'h0000_01B3, 32'h10, 0, 1, 1, 1);
        // add x3,x0,x0 with ex_rd = 0: no hazard.
        step(1, 32'h0000_0013, 32'h14, 0, 1, 0, 1);
        // Redirect while PC 0x20 would be captured; target 0x100 follows.
        step(1, 32'h0000_0013, 32'h20, 1, 0, 0, 1);
        step(1, 32'h0020_81B3, 32'h100, 0, 0, 0, 1);
        // add x3,x1,x2 in ID with load to x2 and redirect together.
        step(1, 32'h0000_0013, 32'h104, 1, 1, 2, 1);
        step(1, 32'h0020_81B3, 32'h200, 0, 0, 0, 1);
        step(1, 32'h0000_0013, 32'h204, 0, 1, 2, 1);
        step(1, 32'h0000_0013, 32'h204, 0, 0, 0, 1);
        step(1, 32'h0020_81B3, 32'h208, 0, 0, 0, 1);
        step(1, 32'h0000_0013, 32'h20C, 0, 1, 1, 1);
        step(1, 32'h0000_0013, 32'h20C, 0, 0, 0, 1);

        // Randomized traffic with IF behaving like a real fetch unit.
        pc = 32'h20C;
        for (int i = 0; i < 600; i++) begin
            rs   = ($urandom_range(0, 59) != 0);
            rd_r = ($urandom_range(0, 7) == 0);
            mr   = ($urandom_range(0, 2) == 0);
            if (!last_stop) pc = pc + 4;
            inst = rand_inst();
            step(rs, inst, pc, rd_r, mr, 5'($urandom_range(0, 3)), 1);
            if (rd_r) pc = {$urandom_range(0, 255), 2'b00} - 4;
            if (!rs) pc = 32'hFFFF_FFF8;
        end

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 20) begin
            @(negedge clk_cpu);
            wait_cyc++;
        end
        #5;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
